axi_frame_writeback: RTL and testbench
======================================

Name: axi_frame_writeback

Overview:
- AXI4 write-burst master that copies one 64x64 4-bit routed frame from the on-chip frame SRAM to DRAM.
- Destination is BASE_ADDR + FRAME_STRIDE*frame_id, which is the same layout the testbench DRAM model reads back for checking.
- Sits between the router core, which issues start and owns the SRAM, and the AXI write channels (aw/w/b) of the top-level chip IO.
- One frame = 128 beats x 128 bits, packed two cells per byte with the low nibble holding the even column.

Parameters:
- ID_WIDTH, 4, AXI ID width.
- DATA_WIDTH, 128, AXI data and SRAM word width.
- ADDR_WIDTH, 32, AXI address width.
- BASE_ADDR, 32'h0001_0000, address of frame 0.
- FRAME_STRIDE, 32'h800, bytes per frame.
- BEATS, 128, beats per frame burst; must be <= 256.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to write back a frame
- frame_id  in  5  frame index; sampled when start is accepted
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after the B response is accepted
- err  out  1  valid with done; high if bresp != 2'b00
- sram_addr  out  7  SRAM word address
- sram_re  out  1  SRAM read enable; read data returns 1 cycle later
- sram_rdata  in  DATA_WIDTH  SRAM read data
- awid_m_inf  out  ID_WIDTH  always 0
- awaddr_m_inf  out  ADDR_WIDTH  burst start address
- awsize_m_inf  out  3  always 3'b100 (16 bytes)
- awburst_m_inf  out  2  always 2'b01 (INCR)
- awlen_m_inf  out  8  always BEATS-1
- awvalid_m_inf  out  1
- awready_m_inf  in  1
- wdata_m_inf  out  DATA_WIDTH
- wlast_m_inf  out  1
- wvalid_m_inf  out  1
- wready_m_inf  in  1
- bid_m_inf  in  ID_WIDTH  ignored
- bresp_m_inf  in  2
- bvalid_m_inf  in  1
- bready_m_inf  out  1

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE, one edge after rst is sampled high.
- Reset mid-burst abandons the transaction immediately. No wlast is sent and the B response is not awaited. The DRAM slave is reset by the same reset.
- FSM IDLE:
  - If start is high, latch frame_id and compute awaddr = BASE_ADDR + FRAME_STRIDE*frame_id (full ADDR_WIDTH arithmetic; frame 31 gives 32'h0001_F800).
  - Set busy=1 and go to AW.
  - Issue prefetch reads of SRAM words 0 and 1.
  - start is ignored whenever busy is high.
- AW:
  - awvalid=1 with stable address and control fields until awready is sampled high.
  - Then awvalid=0 on the next edge and go to W.
  - No W beat is issued before the AW handshake completes.
- W:
  - 2-entry FIFO fed by the SRAM prefetcher. wdata is the FIFO head; wvalid = FIFO not empty.
  - Once asserted, wvalid and wdata stay stable until wready is sampled high.
  - The prefetcher issues sram_re only if (FIFO occupancy + reads in flight) < 2 and the issued-read count is < BEATS. It never overruns the FIFO, even if wready is low for an arbitrary time.
  - Beat counter runs 0..BEATS-1. wlast = (count == BEATS-1) && wvalid.
  - Handshake on the last beat -> go to B.
  - Sustained throughput: 1 beat/cycle while wready is held high.
- B:
  - bready=1.
  - On bvalid, sample bresp, go to IDLE, pulse done with err = (bresp != 0), and deassert busy in the same cycle as done.
- done and start in the same cycle: done completes first. The start is accepted because the FSM has returned to IDLE; the next frame then begins.
- Minimum latency with an always-ready slave and bvalid one cycle after wlast: start to done = 1 (AW) + 128 (W) + 2 cycles.
- sram_addr equals the issued-read count; it never exceeds BEATS-1.

Decomposition:
- Package axi_wb_pkg holds:
  - AXI constants: SIZE_16B=3'b100, BURST_INCR=2'b01, RESP_OKAY=2'b00.
  - The FSM state enum {IDLE, AW, W, B}.
  - BASE_ADDR and FRAME_STRIDE defaults.
- One sub-module, wb_prefetch_fifo: 2-entry DATA_WIDTH FIFO plus the in-flight read tracker, with push/pop/credit outputs.
- The top level contains only the FSM, the address calculation and the beat counter.

Test Plan:
- Always-ready slave, frame_id=3, SRAM word k = {16{k[7:0]}}.
  - Required: awaddr=32'h0001_1800, awlen=127, awsize=3'b100, awburst=2'b01.
  - Required: 128 beats in order, with wlast only on beat 127.
  - Required: DRAM bytes 0x11800..0x11FFF match the SRAM contents; done at cycle 131; err=0.
- Random wready (50% duty) and a 5-cycle awready delay.
  - Required: data is identical to the first test, and no beat is duplicated or dropped.
  - Required: wvalid/wdata never change while wvalid=1 and wready=0.
  - Required: sram_re never issued with 2 entries outstanding.
- frame_id=31 and bresp=2'b10 -> awaddr=32'h0001_F800; done with err=1.
- start pulsed again at beats 10 and 50 -> ignored; exactly one AW; busy stays 1.
- rst asserted at beat 60 -> next cycle all outputs 0 and busy=0. A new start with frame_id=0 then completes a clean burst to 32'h0001_0000.
- start held high for 2 frames (done and start coincide) -> two back-to-back bursts with no idle AW gap beyond 1 cycle; done pulses twice.

Source files
------------

// File: rtl/axi_wb_pkg.sv
// Shared constants and state type for the frame write-back AXI master.
package axi_wb_pkg;

    localparam logic [2:0]  SIZE_16B         = 3'b100;
    localparam logic [1:0]  BURST_INCR       = 2'b01;
    localparam logic [1:0]  RESP_OKAY        = 2'b00;

    localparam logic [31:0] DEF_BASE_ADDR    = 32'h0001_0000;
    localparam logic [31:0] DEF_FRAME_STRIDE = 32'h0000_0800;

    typedef enum logic [1:0] {
        IDLE,
        AW,
        W,
        B
    } wbState_e;

endpackage

// File: rtl/wb_prefetch_fifo.sv
// SRAM prefetcher feeding a 2-entry FIFO; tracks the one read in flight so the FIFO never overruns.
module wb_prefetch_fifo
    import axi_wb_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int BEATS      = 128,
    parameter int CNT_W      = $clog2(BEATS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  kick_i,
    input  logic                  active_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic                  sramRe_o,
    output logic [6:0]            sramAddr_o,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic                  notEmpty_o,
    output logic                  credit_o,
    output logic                  push_o
);

    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  wrPtr_q;
    logic                  rdPtr_q;
    logic [1:0]            count_q;
    logic                  inFlight_q;
    logic [CNT_W-1:0]      issued_q;

    logic                  popEn;
    logic [1:0]            pending;

    // A slot freed by this cycle's pop is already usable, which keeps the burst at one beat per cycle.
    always_comb begin
        popEn      = pop_i && (count_q != 2'd0);
        push_o     = inFlight_q;
        pending    = count_q - 2'(popEn) + 2'(inFlight_q);
        credit_o   = (pending < 2'd2) && (issued_q < CNT_W'(BEATS));
        sramRe_o   = kick_i || (active_i && credit_o);
        sramAddr_o = 7'(issued_q);
        head_o     = mem_q[rdPtr_q];
        notEmpty_o = (count_q != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wrPtr_q    <= 1'b0;
            rdPtr_q    <= 1'b0;
            count_q    <= 2'd0;
            inFlight_q <= 1'b0;
            issued_q   <= '0;
        end else begin
            inFlight_q <= sramRe_o;
            if (sramRe_o) begin
                issued_q <= issued_q + CNT_W'(1);
            end
            if (push_o) begin
                mem_q[wrPtr_q] <= rdata_i;
                wrPtr_q        <= ~wrPtr_q;
            end
            if (popEn) begin
                rdPtr_q <= ~rdPtr_q;
            end
            count_q <= count_q + 2'(push_o) - 2'(popEn);
        end
    end

endmodule

// File: rtl/axi_frame_writeback.sv
// AXI4 write-burst master copying one routed frame from the frame SRAM to DRAM at BASE_ADDR + FRAME_STRIDE*frame_id.
module axi_frame_writeback
    import axi_wb_pkg::*;
#(
    parameter int                    ID_WIDTH     = 4,
    parameter int                    DATA_WIDTH   = 128,
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = ADDR_WIDTH'(DEF_BASE_ADDR),
    parameter logic [ADDR_WIDTH-1:0] FRAME_STRIDE = ADDR_WIDTH'(DEF_FRAME_STRIDE),
    parameter int                    BEATS        = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4:0]            frame_id,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [6:0]            sram_addr,
    output logic                  sram_re,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    output logic [ID_WIDTH-1:0]   awid_m_inf,
    output logic [ADDR_WIDTH-1:0] awaddr_m_inf,
    output logic [2:0]            awsize_m_inf,
    output logic [1:0]            awburst_m_inf,
    output logic [7:0]            awlen_m_inf,
    output logic                  awvalid_m_inf,
    input  logic                  awready_m_inf,
    output logic [DATA_WIDTH-1:0] wdata_m_inf,
    output logic                  wlast_m_inf,
    output logic                  wvalid_m_inf,
    input  logic                  wready_m_inf,
    input  logic [ID_WIDTH-1:0]   bid_m_inf,
    input  logic [1:0]            bresp_m_inf,
    input  logic                  bvalid_m_inf,
    output logic                  bready_m_inf
);

    wbState_e              state_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic                  awvalid_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
    logic                  bready_q;
    logic [7:0]            beatCnt_q;

    logic                  fifoNotEmpty;
    logic [DATA_WIDTH-1:0] fifoHead;
    logic                  wHandshake;
    logic                  unusedCredit;
    logic                  unusedPush;
    logic                  unusedBid;

    assign unusedBid     = ^bid_m_inf;

    assign awid_m_inf    = '0;
    assign awsize_m_inf  = SIZE_16B;
    assign awburst_m_inf = BURST_INCR;
    assign awlen_m_inf   = 8'(BEATS - 1);
    assign awaddr_m_inf  = awaddr_q;
    assign awvalid_m_inf = awvalid_q;
    assign bready_m_inf  = bready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

    // W beats are only presented after the AW handshake, even though the FIFO fills during AW.
    assign wvalid_m_inf  = (state_q == W) && fifoNotEmpty;
    assign wdata_m_inf   = fifoHead;
    assign wlast_m_inf   = wvalid_m_inf && (beatCnt_q == 8'(BEATS - 1));
    assign wHandshake    = wvalid_m_inf && wready_m_inf;

    wb_prefetch_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .BEATS      (BEATS)
    ) u_prefetch (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (state_q == B),
        .kick_i     ((state_q == IDLE) && start),
        .active_i   ((state_q == AW) || (state_q == W)),
        .pop_i      (wHandshake),
        .rdata_i    (sram_rdata),
        .sramRe_o   (sram_re),
        .sramAddr_o (sram_addr),
        .head_o     (fifoHead),
        .notEmpty_o (fifoNotEmpty),
        .credit_o   (unusedCredit),
        .push_o     (unusedPush)
    );

    // done is a one-cycle pulse, so a start arriving with it is accepted straight from IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            awaddr_q  <= '0;
            awvalid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            bready_q  <= 1'b0;
            beatCnt_q <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (start) begin
                        awaddr_q  <= BASE_ADDR + FRAME_STRIDE * ADDR_WIDTH'(frame_id);
                        awvalid_q <= 1'b1;
                        busy_q    <= 1'b1;
                        beatCnt_q <= 8'd0;
                        state_q   <= AW;
                    end
                end
                AW: begin
                    if (awready_m_inf) begin
                        awvalid_q <= 1'b0;
                        state_q   <= W;
                    end
                end
                W: begin
                    if (wHandshake) begin
                        beatCnt_q <= beatCnt_q + 8'd1;
                        if (beatCnt_q == 8'(BEATS - 1)) begin
                            bready_q <= 1'b1;
                            state_q  <= B;
                        end
                    end
                end
                B: begin
                    if (bvalid_m_inf) begin
                        bready_q <= 1'b0;
                        done_q   <= 1'b1;
                        err_q    <= (bresp_m_inf != RESP_OKAY);
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_frame_writeback.sv
// Directed bench: SRAM and AXI slave models driven cycle by cycle, checks on burst shape, data and timing.
module tb_axi_frame_writeback;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [4:0]   frame_id = 5'd0;
    logic         busy, done, err;
    logic [6:0]   sram_addr;
    logic         sram_re;
    logic [127:0] sram_rdata = '0;
    logic [3:0]   awid_m_inf;
    logic [31:0]  awaddr_m_inf;
    logic [2:0]   awsize_m_inf;
    logic [1:0]   awburst_m_inf;
    logic [7:0]   awlen_m_inf;
    logic         awvalid_m_inf;
    logic         awready_m_inf = 1'b0;
    logic [127:0] wdata_m_inf;
    logic         wlast_m_inf;
    logic         wvalid_m_inf;
    logic         wready_m_inf = 1'b0;
    logic [3:0]   bid_m_inf = 4'd0;
    logic [1:0]   bresp_m_inf = 2'd0;
    logic         bvalid_m_inf = 1'b0;
    logic         bready_m_inf;

    axi_frame_writeback dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .frame_id      (frame_id),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .sram_addr     (sram_addr),
        .sram_re       (sram_re),
        .sram_rdata    (sram_rdata),
        .awid_m_inf    (awid_m_inf),
        .awaddr_m_inf  (awaddr_m_inf),
        .awsize_m_inf  (awsize_m_inf),
        .awburst_m_inf (awburst_m_inf),
        .awlen_m_inf   (awlen_m_inf),
        .awvalid_m_inf (awvalid_m_inf),
        .awready_m_inf (awready_m_inf),
        .wdata_m_inf   (wdata_m_inf),
        .wlast_m_inf   (wlast_m_inf),
        .wvalid_m_inf  (wvalid_m_inf),
        .wready_m_inf  (wready_m_inf),
        .bid_m_inf     (bid_m_inf),
        .bresp_m_inf   (bresp_m_inf),
        .bvalid_m_inf  (bvalid_m_inf),
        .bready_m_inf  (bready_m_inf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic       rstReq = 1'b1;
    logic       startReq = 1'b0;
    logic [4:0] frameReq = 5'd0;
    int         awDelay = 0;
    bit         wreadyRandom = 1'b0;
    logic [1:0] brespCfg = 2'b00;
    logic [7:0] salt = 8'h00;

    int awWait = 0, awCount = 0, doneCount = 0, beatIdx = 0, readsIssued = 0, lastBeats = 0;
    int dataErrs = 0, lastErrs = 0, stableErrs = 0, overrunErrs = 0, addrErrs = 0;
    int wBeforeAw = 0, busyErrs = 0;
    int acceptCycle = 0, doneCycle = 0, awRiseCycle = 0, firstDone = 0;
    logic [31:0]  capAddr = '0;
    logic [7:0]   capLen = '0;
    logic [2:0]   capSize = '0;
    logic [1:0]   capBurst = '0;
    logic         doneErr = 1'b0;
    bit           awSeen = 0, bPending = 0, readPend = 0, inBurst = 0, prevStall = 0, prevAwvalid = 0;
    logic [6:0]   readAddr = '0;
    logic [127:0] prevData = '0;

    function automatic logic [127:0] pattern(input int k);
        logic [7:0] b;
        b = 8'(k) ^ salt;
        return {16{b}};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic resetCounters();
        awCount = 0; doneCount = 0; dataErrs = 0; lastErrs = 0; stableErrs = 0;
        overrunErrs = 0; addrErrs = 0; wBeforeAw = 0; busyErrs = 0; lastBeats = 0;
    endtask

    // One clock cycle: drive inputs after the falling edge, observe and score, then return SRAM data.
    task automatic applyStimulus();
        @(negedge clk);
        rst           = rstReq;
        start         = startReq;
        frame_id      = frameReq;
        awready_m_inf = (awWait >= awDelay);
        wready_m_inf  = wreadyRandom ? 1'($urandom_range(0, 1)) : 1'b1;
        bvalid_m_inf  = bPending;
        bresp_m_inf   = brespCfg;
        #1;
        cyc++;
        if (rst) begin
            awWait = 0; awSeen = 0; bPending = 0; readPend = 0; inBurst = 0;
            prevStall = 0; beatIdx = 0; readsIssued = 0; prevAwvalid = 0;
        end else begin
            if (done) begin
                doneCount++; doneErr = err; doneCycle = cyc; lastBeats = beatIdx;
                beatIdx = 0; readsIssued = 0; awSeen = 0;
            end
            if (inBurst && !done && !busy) busyErrs++;
            if (done) inBurst = 0;
            if (start && !busy) begin
                inBurst = 1; acceptCycle = cyc;
            end
            if (awvalid_m_inf && !prevAwvalid) awRiseCycle = cyc;
            prevAwvalid = awvalid_m_inf;
            if (wvalid_m_inf && !awSeen) wBeforeAw++;
            if (awvalid_m_inf) begin
                if (awready_m_inf) begin
                    awCount++; awWait = 0; awSeen = 1;
                    capAddr = awaddr_m_inf; capLen = awlen_m_inf;
                    capSize = awsize_m_inf; capBurst = awburst_m_inf;
                end else begin
                    awWait++;
                end
            end
            if (prevStall && (!wvalid_m_inf || wdata_m_inf !== prevData)) stableErrs++;
            prevStall = wvalid_m_inf && !wready_m_inf;
            prevData  = wdata_m_inf;
            if (wvalid_m_inf ? (wlast_m_inf !== (beatIdx == 127)) : (wlast_m_inf !== 1'b0)) lastErrs++;
            if (bvalid_m_inf && bready_m_inf) bPending = 0;
            if (wvalid_m_inf && wready_m_inf) begin
                if (wdata_m_inf !== pattern(beatIdx)) dataErrs++;
                if (wlast_m_inf) bPending = 1;
                beatIdx++;
            end
            readPend = sram_re;
            if (sram_re) begin
                if (sram_addr !== 7'(readsIssued)) addrErrs++;
                readAddr = sram_addr;
                readsIssued++;
            end
            if (readsIssued - beatIdx > 2) overrunErrs++;
        end
        @(posedge clk);
        #1;
        sram_rdata = readPend ? pattern(int'(readAddr)) : '0;
    endtask

    task automatic runUntilDone(input int target, input int budget);
        for (int i = 0; i < budget && doneCount < target; i++) begin
            applyStimulus();
        end
    endtask

    initial begin
        $display("[TB] reset");
        rstReq = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_handshakes", {awvalid_m_inf, wvalid_m_inf, wlast_m_inf, bready_m_inf}, 4'b0000);
        checkOutput("reset_done_err", {done, err}, 2'b00);
        checkOutput("reset_sram", {sram_re, sram_addr}, 8'h00);
        rstReq = 1'b0;
        applyStimulus();

        $display("[TB] frame 3, always-ready slave");
        resetCounters();
        frameReq = 5'd3; startReq = 1'b1;
        applyStimulus();
        startReq = 1'b0;
        runUntilDone(1, 400);
        checkOutput("t1_done_count", doneCount, 1);
        checkOutput("t1_aw_count", awCount, 1);
        checkOutput("t1_awaddr", capAddr, 32'h0001_1800);
        checkOutput("t1_awlen", capLen, 8'd127);
        checkOutput("t1_awsize", capSize, 3'b100);
        checkOutput("t1_awburst", capBurst, 2'b01);
        checkOutput("t1_beats", lastBeats, 128);
        checkOutput("t1_data_errs", dataErrs, 0);
        checkOutput("t1_wlast_errs", lastErrs, 0);
        checkOutput("t1_latency", doneCycle - acceptCycle, 131);
        checkOutput("t1_err", doneErr, 1'b0);
        checkOutput("t1_sram_addr_errs", addrErrs, 0);

        $display("[TB] frame 3, random wready, awready delayed 5");
        resetCounters();
        wreadyRandom = 1'b1; awDelay = 5;
        startReq = 1'b1;
        applyStimulus();
        startReq = 1'b0;
        runUntilDone(1, 2000);
        checkOutput("t2_done_count", doneCount, 1);
        checkOutput("t2_awaddr", capAddr, 32'h0001_1800);
        checkOutput("t2_beats", lastBeats, 128);
        checkOutput("t2_data_errs", dataErrs, 0);
        checkOutput("t2_stable_errs", stableErrs, 0);
        checkOutput("t2_overrun_errs", overrunErrs, 0);
        checkOutput("t2_w_before_aw", wBeforeAw, 0);
        checkOutput("t2_wlast_errs", lastErrs, 0);
        checkOutput("t2_sram_addr_errs", addrErrs, 0);

        $display("[TB] frame 31 with SLVERR");
        resetCounters();
        wreadyRandom = 1'b0; awDelay = 0; brespCfg = 2'b10; salt = 8'h5a;
        frameReq = 5'd31; startReq = 1'b1;
        applyStimulus();
        startReq = 1'b0;
        runUntilDone(1, 400);
        checkOutput("t3_done_count", doneCount, 1);
        checkOutput("t3_awaddr", capAddr, 32'h0001_F800);
        checkOutput("t3_err", doneErr, 1'b1);
        checkOutput("t3_data_errs", dataErrs, 0);

        $display("[TB] frame 5 with stray starts at beats 10 and 50");
        resetCounters();
        brespCfg = 2'b00; salt = 8'hc3;
        frameReq = 5'd5; startReq = 1'b1;
        applyStimulus();
        frameReq = 5'd7;
        for (int i = 0; i < 400 && doneCount < 1; i++) begin
            startReq = (beatIdx == 10) || (beatIdx == 50);
            applyStimulus();
        end
        startReq = 1'b0;
        checkOutput("t4_done_count", doneCount, 1);
        checkOutput("t4_aw_count", awCount, 1);
        checkOutput("t4_awaddr", capAddr, 32'h0001_2800);
        checkOutput("t4_busy_errs", busyErrs, 0);
        checkOutput("t4_beats", lastBeats, 128);
        applyStimulus();
        checkOutput("t4_no_restart", {busy, awvalid_m_inf}, 2'b00);

        $display("[TB] reset at beat 60, then frame 0");
        resetCounters();
        frameReq = 5'd9; startReq = 1'b1;
        applyStimulus();
        startReq = 1'b0;
        for (int i = 0; i < 400 && beatIdx < 60; i++) begin
            applyStimulus();
        end
        checkOutput("t5_reached_beat60", beatIdx, 60);
        rstReq = 1'b1;
        applyStimulus();
        rstReq = 1'b0;
        checkOutput("t5_busy", busy, 1'b0);
        checkOutput("t5_handshakes", {awvalid_m_inf, wvalid_m_inf, wlast_m_inf, bready_m_inf}, 4'b0000);
        checkOutput("t5_sram", {sram_re, sram_addr}, 8'h00);
        checkOutput("t5_awaddr_wdata", {awaddr_m_inf, wdata_m_inf}, 160'd0);
        resetCounters();
        salt = 8'h21; frameReq = 5'd0; startReq = 1'b1;
        applyStimulus();
        startReq = 1'b0;
        runUntilDone(1, 400);
        checkOutput("t5_done_count", doneCount, 1);
        checkOutput("t5_awaddr", capAddr, 32'h0001_0000);
        checkOutput("t5_beats", lastBeats, 128);
        checkOutput("t5_data_errs", dataErrs, 0);
        checkOutput("t5_err", doneErr, 1'b0);

        $display("[TB] start held for two frames");
        resetCounters();
        salt = 8'h00; frameReq = 5'd4; startReq = 1'b1;
        for (int i = 0; i < 400 && doneCount < 1; i++) begin
            applyStimulus();
        end
        firstDone = doneCycle;
        startReq = 1'b0;
        runUntilDone(2, 400);
        checkOutput("t6_done_count", doneCount, 2);
        checkOutput("t6_aw_count", awCount, 2);
        checkOutput("t6_aw_gap", awRiseCycle - firstDone, 1);
        checkOutput("t6_awaddr", capAddr, 32'h0001_2000);
        checkOutput("t6_beats", lastBeats, 128);
        checkOutput("t6_data_errs", dataErrs, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
